// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch-stage bus between decode/hazard/imem and the PC sequencer
//
// Ports (interface signals):
//   stall, imem_ready                 hazard unit hold / instruction memory completion
//   jump_req, jump_index              J/JAL request and 26-bit instr_index
//   branch_req, branch_taken,
//   branch_offset                     conditional branch request, outcome, signed immediate
//   jr_req, jr_addr                   JR/JALR request and register target
//   exc_req                           single-cycle exception pulse
//   pc, pc_plus4, fetch_valid         current fetch address, pc+4, fetch request live
//   flush                             kill the instruction entering IF/ID this cycle
//   misaligned, epc                   misaligned-JR pulse, excepting decode address
// Modports: master = decode/hazard/imem side, slave = pc_sequencer.
interface pc_sequencer_if;
  logic        stall;
  logic        imem_ready;
  logic        jump_req;
  logic [25:0] jump_index;
  logic        branch_req;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jr_req;
  logic [31:0] jr_addr;
  logic        exc_req;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush;
  logic        misaligned;
  logic [31:0] epc;

  modport master (
    output stall, imem_ready, jump_req, jump_index, branch_req, branch_taken,
           branch_offset, jr_req, jr_addr, exc_req,
    input  pc, pc_plus4, fetch_valid, flush, misaligned, epc
  );

  modport slave (
    input  stall, imem_ready, jump_req, jump_index, branch_req, branch_taken,
           branch_offset, jr_req, jr_addr, exc_req,
    output pc, pc_plus4, fetch_valid, flush, misaligned, epc
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC controller for the MIPS fetch stage
//
// Owns the program counter and picks each cycle between sequential fetch,
// J/JAL, branch, JR and the exception vector, arbitrated against hazard
// stalls and instruction-memory wait states. Produces the IF/ID flush.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of pc_sequencer_if (requests in, pc/flush/epc out)
//
// Configuration macro: BRANCH_DELAY_SLOT_EN
//   defined   - taken jump/JR/branch do not flush; the pc_id+4 fetch is the delay slot
//   undefined - every taken jump/JR/branch flushes in its acceptance cycle
// Exceptions always flush.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  bus
);

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic REDIRECT_FLUSH = 1'b0;
`else
  localparam logic REDIRECT_FLUSH = 1'b1;
`endif

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    EXC_PEND = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_id_q;
  logic [31:0] epc_q;
  logic        fetch_valid_q;
  logic        misaligned_q;
  logic        mis_pend_q;    // pending exception came from a misaligned JR

  logic [31:0] pc_plus4;
  logic [31:0] pc_id_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] redirect_target;
  logic        jr_misaligned;
  logic        exc_event;
  logic        accept;
  logic        redirect;
  logic        flush_c;

  assign pc_plus4      = pc_q + 32'd4;
  assign pc_id_plus4   = pc_id_q + 32'd4;
  assign jump_target   = {pc_id_plus4[31:28], bus.jump_index, 2'b00};
  assign branch_target = pc_id_plus4 + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};

  assign jr_misaligned = bus.jr_req && (bus.jr_addr[1:0] != 2'b00);
  // Exceptions bypass the stall; only RUN can raise a new one.
  assign exc_event     = (state_q == RUN) && (bus.exc_req || jr_misaligned);
  assign accept        = (state_q == RUN) && bus.imem_ready && !bus.stall;
  assign redirect      = bus.jr_req || bus.jump_req || (bus.branch_req && bus.branch_taken);

  always_comb begin
    redirect_target = pc_plus4;
    if (bus.jr_req)
      redirect_target = bus.jr_addr;
    else if (bus.jump_req)
      redirect_target = jump_target;
    else if (bus.branch_req && bus.branch_taken)
      redirect_target = branch_target;
  end

  // Flush is asserted in the cycle the redirect or exception is accepted.
  always_comb begin
    flush_c = 1'b0;
    if (state_q == EXC_PEND)
      flush_c = bus.imem_ready;
    else if (exc_event)
      flush_c = bus.imem_ready;
    else if (accept && redirect)
      flush_c = REDIRECT_FLUSH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      pc_id_q       <= 32'd0;
      epc_q         <= 32'd0;
      fetch_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      mis_pend_q    <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      // The fetch at pc completes into decode, even if it is then flushed.
      if (bus.imem_ready && !bus.stall && fetch_valid_q)
        pc_id_q <= pc_q;
      case (state_q)
        BOOT: begin
          state_q       <= RUN;
          fetch_valid_q <= 1'b1;
        end
        RUN: begin
          if (exc_event) begin
            epc_q <= pc_id_q;
            if (bus.imem_ready) begin
              pc_q         <= EXC_VECTOR;
              misaligned_q <= jr_misaligned;
            end else begin
              // Fetch still outstanding: hold pc until memory completes it.
              state_q    <= EXC_PEND;
              mis_pend_q <= jr_misaligned;
            end
          end else if (accept) begin
            pc_q <= redirect ? redirect_target : pc_plus4;
          end
        end
        EXC_PEND: begin
          // Further exc_req pulses are absorbed here; epc keeps the first.
          if (bus.imem_ready) begin
            pc_q         <= EXC_VECTOR;
            misaligned_q <= mis_pend_q;
            mis_pend_q   <= 1'b0;
            state_q      <= RUN;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.flush       = flush_c;
  assign bus.misaligned  = misaligned_q;
  assign bus.epc         = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard testbench for pc_sequencer
module tb_pc_sequencer;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic RF = 1'b0;
`else
  localparam logic RF = 1'b1;
`endif

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  typedef struct {
    string       tag;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];

  pc_sequencer_if bus();

  pc_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: check combinational flush, queue the expected next pc, then
  // compare the popped expectation against what the DUT shows after the edge.
  task automatic cyc(input string tag, input logic exp_flush, input logic [31:0] exp_pc);
    exp_t e;
    #1;
    check_eq({tag, ".flush"}, {31'd0, bus.flush}, {31'd0, exp_flush});
    e.tag = tag;
    e.pc  = exp_pc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq({e.tag, ".pc"}, bus.pc, e.pc);
    end
  endtask

  task automatic clear_reqs();
    bus.stall         = 1'b0;
    bus.imem_ready    = 1'b1;
    bus.jump_req      = 1'b0;
    bus.jump_index    = 26'd0;
    bus.branch_req    = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = 16'd0;
    bus.jr_req        = 1'b0;
    bus.jr_addr       = 32'd0;
    bus.exc_req       = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clear_reqs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.pc", bus.pc, 32'h0);
    check_eq("rst.pc_plus4", bus.pc_plus4, 32'h4);
    check_eq("rst.fv", {31'd0, bus.fetch_valid}, 32'd0);
    check_eq("rst.flush", {31'd0, bus.flush}, 32'd0);
    check_eq("rst.mis", {31'd0, bus.misaligned}, 32'd0);
    check_eq("rst.epc", bus.epc, 32'h0);
    rst_n = 1'b1;

    cyc("boot", 1'b0, 32'h0);
    check_eq("boot.fv", {31'd0, bus.fetch_valid}, 32'd1);
    cyc("seq0", 1'b0, 32'h4);
    cyc("seq1", 1'b0, 32'h8);

    bus.jr_req = 1'b1; bus.jr_addr = 32'h4000_0010;
    cyc("jr_far", RF, 32'h4000_0010);
    clear_reqs();
    cyc("fill0", 1'b0, 32'h4000_0014);
    bus.jump_req = 1'b1; bus.jump_index = 26'h000_0040;
    cyc("jump", RF, 32'h4000_0100);
    clear_reqs();

    bus.jr_req = 1'b1; bus.jr_addr = 32'h100;
    cyc("jr_100", RF, 32'h100);
    clear_reqs();
    cyc("fill1", 1'b0, 32'h104);
    bus.branch_req = 1'b1; bus.branch_taken = 1'b1; bus.branch_offset = 16'hFFFE;
    cyc("br_taken", RF, 32'hFC);
    bus.branch_taken = 1'b0;
    cyc("br_nt", 1'b0, 32'h100);
    clear_reqs();

    bus.jr_req = 1'b1; bus.jr_addr = 32'h300;
    bus.jump_req = 1'b1; bus.jump_index = 26'h123;
    bus.branch_req = 1'b1; bus.branch_taken = 1'b1; bus.branch_offset = 16'h0010;
    bus.stall = 1'b1;
    cyc("stall0", 1'b0, 32'h100);
    cyc("stall1", 1'b0, 32'h100);
    check_eq("stall.fv", {31'd0, bus.fetch_valid}, 32'd1);
    check_eq("stall.epc", bus.epc, 32'h0);
    bus.stall = 1'b0;
    cyc("prio", RF, 32'h300);
    clear_reqs();

    bus.jump_req = 1'b1; bus.imem_ready = 1'b0;
    cyc("imem_wait", 1'b0, 32'h300);
    clear_reqs();
    cyc("seq2", 1'b0, 32'h304);

    bus.jr_req = 1'b1; bus.jr_addr = 32'h203;
    cyc("mis_jr", 1'b1, 32'h80);
    check_eq("mis_jr.mis", {31'd0, bus.misaligned}, 32'd1);
    check_eq("mis_jr.epc", bus.epc, 32'h300);
    clear_reqs();
    cyc("after_mis", 1'b0, 32'h84);
    check_eq("after_mis.mis", {31'd0, bus.misaligned}, 32'd0);

    bus.imem_ready = 1'b0; bus.exc_req = 1'b1;
    cyc("exc_w0", 1'b0, 32'h84);
    cyc("exc_w1", 1'b0, 32'h84);
    bus.exc_req = 1'b0;
    cyc("exc_w2", 1'b0, 32'h84);
    check_eq("exc_w.epc", bus.epc, 32'h80);
    bus.imem_ready = 1'b1;
    cyc("exc_go", 1'b1, 32'h80);
    check_eq("exc_go.epc", bus.epc, 32'h80);
    check_eq("exc_go.mis", {31'd0, bus.misaligned}, 32'd0);

    bus.imem_ready = 1'b0; bus.exc_req = 1'b1;
    cyc("exc2", 1'b0, 32'h80);
    bus.exc_req = 1'b0;
    rst_n = 1'b0;
    cyc("rst_pend", 1'b0, 32'h0);
    check_eq("rst_pend.fv", {31'd0, bus.fetch_valid}, 32'd0);
    check_eq("rst_pend.epc", bus.epc, 32'h0);
    rst_n = 1'b1; bus.imem_ready = 1'b1;
    cyc("boot2", 1'b0, 32'h0);
    cyc("seq3", 1'b0, 32'h4);
    cyc("seq4", 1'b0, 32'h8);

    bus.stall = 1'b1; bus.exc_req = 1'b1;
    cyc("exc_stall", 1'b1, 32'h80);
    check_eq("exc_stall.epc", bus.epc, 32'h4);
    clear_reqs();

    bus.jr_req = 1'b1; bus.jr_addr = 32'hFFFF_FFFC;
    cyc("jr_top", RF, 32'hFFFF_FFFC);
    clear_reqs();
    check_eq("top.pc_plus4", bus.pc_plus4, 32'h0);
    cyc("wrap", 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
